uart_tx: RTL
============

// Module: uart_tx
//
// PURPOSE
//   Console-output end of the core's UART write port. Accepts byte writes
//   (uart_dout/uart_we from the MEM stage) into a small FIFO. Serializes each
//   byte onto a single txd line as an 8N1 frame at a fixed clocks-per-bit rate.
//   Sits at the top level between the core and the board pin. It decouples the
//   1-cycle store pulses from the slow serial line.
//
// PARAMETERS
//   CLK_DIV          16  clock cycles per serial bit; legal range >= 2
//   FIFO_DEPTH_LOG2  4   FIFO holds 2**FIFO_DEPTH_LOG2 bytes (16 by default)
//
// PORTS
//   clk       in   1   system clock; the only clock
//   reset     in   1   synchronous, active-high reset
//   din       in   32  write data; only din[7:0] is used, din[31:8] is ignored
//   we        in   1   write strobe; one byte is pushed per cycle that we=1
//   txd       out  1   serial output; idle high, 8N1, LSB first
//   busy      out  1   1 while FIFO is non-empty or a frame is in flight
//   full      out  1   FIFO holds 2**FIFO_DEPTH_LOG2 entries
//   overflow  out  1   sticky; a write arrived while full; cleared only by reset
//
// BEHAVIOUR
//   Reset (sync, active-high) puts the block in this state on the next edge:
//     - txd=1, busy=0, full=0, overflow=0
//     - FIFO empty, pointers=0, count=0, state IDLE, counters 0
//     - reset mid-frame aborts the frame: txd=1 on the edge after reset, no resume
//   FIFO:
//     - circular buffer; rd/wr pointers are FIFO_DEPTH_LOG2 bits and wrap naturally
//     - count is FIFO_DEPTH_LOG2+1 bits; full = (count == 2**FIFO_DEPTH_LOG2)
//     - push: we=1 && !full -> mem[wr]<=din[7:0], wr++
//     - we=1 && full -> byte dropped, overflow<=1; this holds even if a pop
//       occurs in the same cycle, because full is the registered value
//     - simultaneous push+pop when not full: count unchanged, both pointers advance
//   Transmit FSM (states IDLE, START, DATA, STOP):
//     - a baud counter counts 0..CLK_DIV-1; each bit lasts exactly CLK_DIV cycles
//     - IDLE: txd=1. If FIFO non-empty: pop into shift reg, txd<=0, goto START,
//       baud=0.
//     - START: hold txd=0. At baud=CLK_DIV-1: txd<=shift[0], bit=0, goto DATA.
//     - DATA: at baud=CLK_DIV-1: if bit==7 then txd<=1, goto STOP;
//       else shift>>=1, txd<=next bit, bit++.
//     - STOP: hold txd=1. At baud=CLK_DIV-1: goto IDLE.
//     - frame = 10*CLK_DIV cycles; back-to-back frames separated by exactly
//       1 idle cycle (the IDLE pop cycle)
//   Latency:
//     - a write sampled at edge n into an empty FIFO with FSM in IDLE is popped
//       at edge n+1
//     - txd is low from edge n+1 (start bit)
//     - txd is a register output, glitch-free
//   busy = (state != IDLE) || (count != 0), registered-equivalent; goes 0 the
//   cycle after the last stop bit ends with the FIFO empty.
//   Widths: baud counter is $clog2(CLK_DIV) bits; bit index is 3 bits; no
//   other arithmetic.
//
// TESTING (CLK_DIV=4, FIFO_DEPTH_LOG2=4 unless noted)
//   1. Single write din=0x00000055 -> txd low 4 cycles from next edge, then
//      1,0,1,0,1,0,1,0 (4 cycles each), then high 4; busy 0 after 41 cycles.
//   2. din=0xDEADBE41 -> frame carries 0x41 only (bits 1,0,0,0,0,0,1,0).
//   3. Writes 0x00 then 0xFF on consecutive cycles -> two frames, exactly
//      1 high idle cycle between the stop bit of frame 1 and the start of
//      frame 2.
//   4. 18 consecutive writes 0x01..0x12 while idle -> the first is popped;
//      16 fill the FIFO and full=1; the 18th is dropped; overflow=1 sticky;
//      17 frames total.
//   5. Assert reset during the DATA bit 3 of a frame holding 2 queued bytes ->
//      txd=1, busy=0, full=0 and FIFO empty after the edge; no further frames.
//   6. CLK_DIV=2: send 0xA5 -> frame length 20 cycles, correct LSB-first bits.

Source files
------------

// File: rtl/uart_tx.sv
// Byte-write FIFO feeding an 8N1 serializer on txd (idle high, LSB first).
// Latency: a write into an empty FIFO with the FSM idle drives the start bit one edge later.
// Backpressure: none upstream; writes while full are dropped and set the sticky overflow flag.
module uart_tx #(
  parameter int CLK_DIV         = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  input  logic        we,
  output logic        txd,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int BW    = $clog2(CLK_DIV);
  localparam logic [BW-1:0]            BAUD_MAX   = BW'(CLK_DIV - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;

  state_t         state;
  logic [BW-1:0]  baud;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;

  logic fifo_nonempty;
  logic push;
  logic pop;

  // Only the low byte is transmitted; the upper bits of the store word are don't-care.
  logic unused_din_hi;
  assign unused_din_hi = ^din[31:8];

  assign fifo_nonempty = (count != '0);
  // full is a function of the count register, so a same-cycle pop never frees a slot for a write.
  assign full          = (count == COUNT_FULL);
  assign push          = we && !full;
  assign pop           = (state == IDLE) && fifo_nonempty;
  assign busy          = (state != IDLE) || fifo_nonempty;

  // Storage array: no reset needed, validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din[7:0];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (we && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Transmit FSM: each of start, 8 data and stop bits is held for CLK_DIV cycles on a registered txd.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (fifo_nonempty) begin
            shift <= mem[rd_ptr];
            txd   <= 1'b0;
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          if (baud == BAUD_MAX) begin
            baud    <= '0;
            txd     <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud == BAUD_MAX) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud == BAUD_MAX) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
